rect_motion_ctl: RTL and testbench

- Parametrised frame-stepped vertical motion controller for the on-screen rectangle.
- Sits between the mouse position path and the rectangle draw stage.
- Follows the mouse until a left-click. Then drops the rectangle under constant gravity to a floor, where it bounces with damping until it comes to rest.
- Steps once per frame on the vsync rising edge. All logic runs in the single clk domain.

---
 rtl/rect_motion_ctl.sv | 166 ++++++++++++++++
 tb/tb_rect_motion_ctl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rect_motion_ctl.sv
// rect_motion_ctl: frame-stepped vertical motion for the on-screen rectangle.
// The rectangle follows the mouse until a left-click, then falls under gravity,
// bounces on the floor with damping, and finally rests on the floor.
//
// state  | meaning
// FOLLOW | rectangle tracks the mouse, ypos clamped to the floor
// FALL   | moving down, speed grows every ACCEL_DIV+1 frames
// RISE   | moving up after a bounce, speed shrinks every ACCEL_DIV+1 frames
// REST   | parked on the floor until the next click
module rect_motion_ctl #(
    parameter int XW         = 12,
    parameter int SPEED_W    = 11,
    parameter int FLOOR      = 536,
    parameter int ACCEL_DIV  = 3,
    parameter int DAMP_SHIFT = 2,
    parameter int MIN_SPEED  = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          left_button,
    input  logic [XW-1:0] xpos,
    input  logic [XW-1:0] ypos,
    input  logic          vsync,
    output logic [XW-1:0] xpos_out,
    output logic [XW-1:0] ypos_out,
    output logic          moving,
    output logic          landed
);

    localparam int DIV_W = (ACCEL_DIV < 2) ? 1 : $clog2(ACCEL_DIV + 1);
    localparam logic [DIV_W-1:0]   DIV_RELOAD = DIV_W'(ACCEL_DIV);
    localparam logic [XW-1:0]      FLOOR_Y    = XW'(FLOOR);
    localparam logic [SPEED_W-1:0] SPEED_MAX  = '1;
    localparam logic [SPEED_W-1:0] MIN_SPD    = SPEED_W'(MIN_SPEED);

    typedef enum logic [1:0] {FOLLOW, FALL, RISE, REST} state_t;

    state_t             state_q, state_d;
    logic [XW-1:0]      xpos_out_q, xpos_out_d;
    logic [XW-1:0]      ypos_out_q, ypos_out_d;
    logic [SPEED_W-1:0] speed_q, speed_d;
    logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
    logic               landed_q, landed_d;
    logic               vsync_q, btn_q;

    logic               tick, btn;
    logic [XW:0]        y_sum, speed_ext;
    logic               hit_floor, underflow;
    logic [XW-1:0]      y_rise, y_follow;
    logic [SPEED_W-1:0] speed_damp, speed_inc;

    // Single-cycle events from the frame sync and the mouse button levels.
    assign tick = vsync & ~vsync_q;
    assign btn  = left_button & ~btn_q;

    // Candidate positions and speeds; the sum is one bit wider so overshoot
    // past the floor is seen before it can wrap.
    assign y_sum      = {1'b0, ypos_out_q} + (XW+1)'(speed_q);
    assign hit_floor  = (y_sum >= {1'b0, FLOOR_Y});
    assign speed_ext  = (XW+1)'(speed_q);
    assign underflow  = (speed_ext > {1'b0, ypos_out_q});
    assign y_rise     = ypos_out_q - speed_ext[XW-1:0];
    assign y_follow   = (ypos > FLOOR_Y) ? FLOOR_Y : ypos;
    assign speed_damp = speed_q - (speed_q >> DAMP_SHIFT);
    assign speed_inc  = (speed_q == SPEED_MAX) ? speed_q : speed_q + 1'b1;

    // State, position, speed and edge-detect registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= FOLLOW;
            xpos_out_q <= '0;
            ypos_out_q <= '0;
            speed_q    <= '0;
            div_cnt_q  <= DIV_RELOAD;
            landed_q   <= 1'b0;
            vsync_q    <= 1'b0;
            btn_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            xpos_out_q <= xpos_out_d;
            ypos_out_q <= ypos_out_d;
            speed_q    <= speed_d;
            div_cnt_q  <= div_cnt_d;
            landed_q   <= landed_d;
            vsync_q    <= vsync;
            btn_q      <= left_button;
        end
    end

    // Next-state logic; a click always wins over a frame tick.
    always_comb begin
        state_d    = state_q;
        xpos_out_d = xpos_out_q;
        ypos_out_d = ypos_out_q;
        speed_d    = speed_q;
        div_cnt_d  = div_cnt_q;
        landed_d   = 1'b0;
        case (state_q)
            FOLLOW: begin
                xpos_out_d = xpos;
                ypos_out_d = y_follow;
                speed_d    = '0;
                div_cnt_d  = DIV_RELOAD;
                if (btn) state_d = FALL;
            end
            FALL: begin
                if (btn) begin
                    state_d = FOLLOW;
                end else if (tick) begin
                    if (hit_floor) begin
                        ypos_out_d = FLOOR_Y;
                        landed_d   = 1'b1;
                        div_cnt_d  = DIV_RELOAD;
                        if (speed_damp >= MIN_SPD) begin
                            speed_d = speed_damp;
                            state_d = RISE;
                        end else begin
                            speed_d = '0;
                            state_d = REST;
                        end
                    end else begin
                        ypos_out_d = y_sum[XW-1:0];
                        if (div_cnt_q == '0) begin
                            div_cnt_d = DIV_RELOAD;
                            speed_d   = speed_inc;
                        end else begin
                            div_cnt_d = div_cnt_q - 1'b1;
                        end
                    end
                end
            end
            RISE: begin
                if (btn) begin
                    state_d = FOLLOW;
                end else if (tick) begin
                    if (speed_q == '0) begin
                        state_d = FALL;
                    end else if (underflow) begin
                        ypos_out_d = '0;
                        speed_d    = '0;
                        state_d    = FALL;
                    end else begin
                        ypos_out_d = y_rise;
                        if (div_cnt_q == '0) begin
                            div_cnt_d = DIV_RELOAD;
                            speed_d   = speed_q - 1'b1;
                        end else begin
                            div_cnt_d = div_cnt_q - 1'b1;
                        end
                    end
                end
            end
            REST: begin
                ypos_out_d = FLOOR_Y;
                if (btn) state_d = FOLLOW;
            end
            default: state_d = FOLLOW;
        endcase
    end

    assign xpos_out = xpos_out_q;
    assign ypos_out = ypos_out_q;
    assign moving   = (state_q == FALL) || (state_q == RISE);
    assign landed   = landed_q;

endmodule

// File: tb/tb_rect_motion_ctl.sv
// Directed bench for rect_motion_ctl: default instance for the main scenarios,
// second instance with FLOOR=400, ACCEL_DIV=1, DAMP_SHIFT=1 for the bounce sweep.
module tb_rect_motion_ctl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        left_button = 1'b0, vsync = 1'b0;
    logic [11:0] xpos = '0, ypos = '0;
    logic [11:0] xpos_out, ypos_out;
    logic        moving, landed;

    logic        left_button_b = 1'b0, vsync_b = 1'b0;
    logic [11:0] xpos_b = '0, ypos_b = '0;
    logic [11:0] xpos_out_b, ypos_out_b;
    logic        moving_b, landed_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rect_motion_ctl dut (
        .clk(clk), .rst(rst), .left_button(left_button), .xpos(xpos), .ypos(ypos),
        .vsync(vsync), .xpos_out(xpos_out), .ypos_out(ypos_out),
        .moving(moving), .landed(landed)
    );

    rect_motion_ctl #(.FLOOR(400), .ACCEL_DIV(1), .DAMP_SHIFT(1)) dut_b (
        .clk(clk), .rst(rst), .left_button(left_button_b), .xpos(xpos_b), .ypos(ypos_b),
        .vsync(vsync_b), .xpos_out(xpos_out_b), .ypos_out(ypos_out_b),
        .moving(moving_b), .landed(landed_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One frame tick; lnd captures landed right after the tick edge.
    task automatic tick(output logic lnd);
        vsync = 1'b1;
        cyc(1);
        lnd = landed;
        vsync = 1'b0;
        cyc(1);
    endtask

    task automatic ticks(input int n);
        logic l;
        for (int i = 0; i < n; i++) tick(l);
    endtask

    task automatic click();
        left_button = 1'b1;
        cyc(1);
        left_button = 1'b0;
        cyc(1);
    endtask

    task automatic tick_b(output logic lnd);
        vsync_b = 1'b1;
        cyc(1);
        lnd = landed_b;
        vsync_b = 1'b0;
        cyc(1);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic l;
        int   landings;
        int   bounce_exp [5] = '{10, 5, 3, 2, 0};

        // Reset state
        cyc(2);
        check("rst_xpos", xpos_out, 0);
        check("rst_ypos", ypos_out, 0);
        check("rst_moving", moving, 0);
        check("rst_landed", landed, 0);
        rst = 1'b0;

        // FOLLOW with clamp to floor
        xpos = 12'd100; ypos = 12'd600;
        cyc(1);
        check("follow_x", xpos_out, 100);
        check("follow_y_clamp", ypos_out, 536);

        // Click at 500, button held high, long vsync pulses
        xpos = 12'd200; ypos = 12'd500;
        cyc(1);
        left_button = 1'b1;
        cyc(1);
        check("click_moving", moving, 1);
        xpos = 12'd50; ypos = 12'd10;
        for (int k = 1; k <= 5; k++) begin
            vsync = 1'b1;
            cyc(100);
            vsync = 1'b0;
            cyc(2);
            check($sformatf("long_tick%0d_y", k), ypos_out, (k == 5) ? 501 : 500);
        end
        check("frozen_x", xpos_out, 200);
        check("held_btn_moving", moving, 1);
        left_button = 1'b0;
        cyc(1);
        click();
        check("abort_moving", moving, 0);

        // Click and tick in the same cycle during FALL
        xpos = 12'd0; ypos = 12'd300;
        cyc(1);
        click();
        ticks(5);
        check("pre_abort_y", ypos_out, 301);
        left_button = 1'b1; vsync = 1'b1;
        cyc(1);
        check("btn_beats_tick_y", ypos_out, 301);
        check("btn_beats_tick_moving", moving, 0);
        left_button = 1'b0; vsync = 1'b0;
        cyc(1);
        check("follow_after_abort_y", ypos_out, 300);

        // Landing with speed 8, bounce at speed 6
        ypos = 12'd416;
        cyc(1);
        click();
        ticks(32);
        check("pre_land8_y", ypos_out, 528);
        tick(l);
        check("land8_pulse", l, 1);
        check("land8_y", ypos_out, 536);
        check("land8_pulse_one_cycle", landed, 0);
        tick(l);
        check("rise6_y1", ypos_out, 530);
        check("rise6_moving", moving, 1);
        ticks(3);
        check("rise6_y4", ypos_out, 512);
        tick(l);
        check("rise5_y", ypos_out, 507);
        click();

        // Landing with speed 2 keeps speed 2
        ypos = 12'd530;
        cyc(1);
        click();
        ticks(8);
        check("pre_land2_y", ypos_out, 534);
        tick(l);
        check("land2_pulse", l, 1);
        tick(l);
        check("rise2_y", ypos_out, 534);
        check("rise2_moving", moving, 1);
        click();

        // Overshoot is clamped to the floor
        ypos = 12'd531;
        cyc(1);
        click();
        ticks(8);
        check("pre_clamp_y", ypos_out, 535);
        tick(l);
        check("clamp_pulse", l, 1);
        check("clamp_y", ypos_out, 536);
        click();

        // Landing with speed 1 goes to REST
        ypos = 12'd535;
        cyc(1);
        click();
        ticks(4);
        tick(l);
        check("land1_pulse", l, 1);
        check("rest_moving", moving, 0);
        tick(l);
        check("rest_no_landing", l, 0);
        check("rest_y", ypos_out, 536);
        xpos = 12'd33; ypos = 12'd100;
        click();
        check("rest_to_follow_y", ypos_out, 100);
        check("rest_to_follow_x", xpos_out, 33);

        // Asynchronous reset mid-FALL
        ypos = 12'd520;
        cyc(1);
        click();
        ticks(2);
        check("pre_rst_y", ypos_out, 520);
        #2 rst = 1'b1;
        #1;
        check("async_rst_y", ypos_out, 0);
        check("async_rst_x", xpos_out, 0);
        check("async_rst_moving", moving, 0);
        cyc(1);
        rst = 1'b0;
        xpos = 12'd77; ypos = 12'd88;
        cyc(2);
        check("post_rst_x", xpos_out, 77);
        check("post_rst_y", ypos_out, 88);
        check("post_rst_moving", moving, 0);

        // Parameter sweep: drop from y=0 to floor 400
        ypos_b = 12'd0;
        cyc(1);
        left_button_b = 1'b1;
        cyc(1);
        left_button_b = 1'b0;
        cyc(1);
        check("b_moving", moving_b, 1);
        landings = 0;
        for (int t = 0; t < 1000 && landings < 5; t++) begin
            tick_b(l);
            check("b_floor_bound", (ypos_out_b <= 12'd400), 1);
            if (l) begin
                check($sformatf("b_land%0d_y", landings), ypos_out_b, 400);
                tick_b(l);
                check($sformatf("b_bounce%0d_speed", landings), 400 - ypos_out_b,
                      bounce_exp[landings]);
                landings++;
            end
        end
        check("b_landings", landings, 5);
        check("b_rest_moving", moving_b, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
